gray_codec_pipe: RTL and testbench

- Parametrised, pipelined binary<->Gray codec with valid/ready handshake on both sides. Successor to the fixed 5-bit combinational binary-to-Gray converter.
- Mode is selectable per transaction: encode (bin->gray) or decode (gray->bin).
- The decode prefix-XOR chain is split across STAGES registers so wide pointers (async-FIFO pointers, encoder positions) meet timing.
- Sits between pointer/counter logic and CDC synchronisers.

---
 rtl/gray_codec_pkg.sv | 28 ++
 rtl/gray_codec_stage.sv | 59 +++++
 rtl/gray_codec_pipe.sv | 88 ++++++++
 tb/tb_gray_codec_pipe.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_codec_pkg.sv
// Shared mode encoding and decode-partition helpers for gray_codec_pipe.
// Decode bits are resolved MSB-first in chunks of chunk_size() per stage.
package gray_codec_pkg;

  typedef logic mode_t;

  localparam mode_t MODE_ENC = 1'b0;
  localparam mode_t MODE_DEC = 1'b1;

  function automatic int chunk_size(int width, int stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic int stage_hi(int width, int stages, int s);
    return width - 1 - s * chunk_size(width, stages);
  endfunction

  function automatic int stage_lo(int width, int stages, int s);
    int lo;
    lo = width - (s + 1) * chunk_size(width, stages);
    return (lo < 0) ? 0 : lo;
  endfunction

  function automatic logic [63:0] bin2gray(logic [63:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One pipeline register of gray_codec_pipe: resolves its decode chunk,
// and in stage 0 also performs the whole binary-to-Gray encode.
module gray_codec_stage
  import gray_codec_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STAGE_IDX = 0,
  parameter int STAGES    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             valid_i,
  input  mode_t            mode_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output mode_t            mode_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int HI = stage_hi(WIDTH, STAGES, STAGE_IDX);
  localparam int LO = stage_lo(WIDTH, STAGES, STAGE_IDX);

  logic             valid_q;
  mode_t            mode_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Bit above the chunk is already binary; the MSB never changes.
  always_comb begin
    data_d = data_i;
    if (mode_i == MODE_DEC) begin
      for (int i = WIDTH - 2; i >= 0; i--) begin
        if (i <= HI && i >= LO) begin
          data_d[i] = data_d[i+1] ^ data_i[i];
        end
      end
    end else if (STAGE_IDX == 0) begin
      data_d = WIDTH'(bin2gray(64'(data_i)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mode_q  <= MODE_ENC;
      data_q  <= '0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      mode_q  <= mode_i;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign data_o  = data_q;

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined binary<->Gray codec with valid/ready on both sides.
// Define GRAY_CODEC_STATS_EN to add saturating enc/dec handshake counters.
module gray_codec_pipe
  import gray_codec_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
`ifdef GRAY_CODEC_STATS_EN
  output logic [15:0]      enc_count,
  output logic [15:0]      dec_count,
`endif
  output logic [WIDTH-1:0] out_data
);

  if (WIDTH < 2 || WIDTH > 64 || STAGES < 1 || STAGES > WIDTH) begin : g_bad
    $error("gray_codec_pipe: illegal WIDTH/STAGES");
  end

  logic             adv;
  logic [STAGES:0]  v;
  logic [STAGES:0]  m;
  logic [WIDTH-1:0] d [STAGES+1];

  // Whole pipe moves in lockstep; no bubble squeezing.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  assign v[0] = in_valid;
  assign m[0] = in_mode;
  assign d[0] = in_data;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    gray_codec_stage #(
      .WIDTH    (WIDTH),
      .STAGE_IDX(s),
      .STAGES   (STAGES)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv_i  (adv),
      .valid_i(v[s]),
      .mode_i (m[s]),
      .data_i (d[s]),
      .valid_o(v[s+1]),
      .mode_o (m[s+1]),
      .data_o (d[s+1])
    );
  end

  assign out_valid = v[STAGES];
  assign out_mode  = m[STAGES];
  assign out_data  = d[STAGES];

`ifdef GRAY_CODEC_STATS_EN
  logic        out_fire;
  logic [15:0] enc_cnt_q;
  logic [15:0] dec_cnt_q;

  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt_q <= '0;
      dec_cnt_q <= '0;
    end else if (out_fire) begin
      if (out_mode == MODE_ENC) begin
        if (enc_cnt_q != 16'hFFFF) enc_cnt_q <= enc_cnt_q + 16'd1;
      end else begin
        if (dec_cnt_q != 16'hFFFF) dec_cnt_q <= dec_cnt_q + 16'd1;
      end
    end
  end

  assign enc_count = enc_cnt_q;
  assign dec_count = dec_cnt_q;
`endif

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Self-checking bench for gray_codec_pipe: directed literals, a queue
// reference model, backpressure/reset scenarios and a parameter sweep.
module tb_gray_codec_pipe;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [63:0] din;
  } item_t;

  function automatic logic [63:0] b2g(logic [63:0] x);
    return x ^ (x >> 1);
  endfunction

  // Binary value is the XOR of all right shifts of the Gray word.
  function automatic logic [63:0] g2b(logic [63:0] g, int w);
    logic [63:0] b;
    b = '0;
    for (int k = 0; k < w; k++) b = b ^ (g >> k);
    return b;
  endfunction

  task automatic chk(string nm, logic mode, logic [63:0] din,
                     logic mo, logic [63:0] dout, int w);
    logic [63:0] exp;
    logic [63:0] back;
    exp  = mode ? g2b(din, w) : b2g(din);
    back = mode ? b2g(dout) : g2b(dout, w);
    checks++;
    if (mo !== mode || dout !== exp) begin
      errors++;
      $display("FAIL %s w=%0d: got mode %0b data %0h, required mode %0b data %0h",
               nm, w, mo, dout, mode, exp);
    end
    checks++;
    if (back !== din) begin
      errors++;
      $display("FAIL %s_roundtrip w=%0d: got %0h required %0h", nm, w, back, din);
    end
  endtask

  task automatic expect1(string nm, logic [63:0] got, logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  // ---------------- main DUT, WIDTH=8 STAGES=2 ----------------
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_mode = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_mode;
  logic [7:0] out_data;
`ifdef GRAY_CODEC_STATS_EN
  logic [15:0] enc_count;
  logic [15:0] dec_count;
`endif

  gray_codec_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mode (out_mode),
`ifdef GRAY_CODEC_STATS_EN
    .enc_count(enc_count),
    .dec_count(dec_count),
`endif
    .out_data (out_data)
  );

  item_t mq[$];
  int    out_fires = 0;
  int    enc_m = 0;
  int    dec_m = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      enc_m = 0;
      dec_m = 0;
    end else begin
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready: got %b required %b", in_ready,
                 !out_valid || out_ready);
      end
      if (out_valid) begin
        if (mq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: out_valid got 1 required 0");
        end else begin
          chk("main_out", mq[0].mode, mq[0].din, out_mode, 64'(out_data), 8);
          if (out_ready) begin
            if (mq[0].mode) begin
              if (dec_m < 65535) dec_m++;
            end else begin
              if (enc_m < 65535) enc_m++;
            end
            void'(mq.pop_front());
            out_fires++;
          end
        end
      end
      if (in_valid && in_ready) mq.push_back('{in_mode, 64'(in_data)});
    end
  end

  // ---------------- WIDTH=5 STAGES=1 literal check DUT ----------------
  logic       iv5 = 1'b0;
  logic       ir5;
  logic       im5 = 1'b0;
  logic [4:0] id5 = '0;
  logic       ov5;
  logic       om5;
  logic [4:0] od5;
`ifdef GRAY_CODEC_STATS_EN
  logic [15:0] ec5;
  logic [15:0] dc5;
`endif

  gray_codec_pipe #(.WIDTH(5), .STAGES(1)) u_w5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (iv5),
    .in_ready (ir5),
    .in_mode  (im5),
    .in_data  (id5),
    .out_valid(ov5),
    .out_ready(1'b1),
    .out_mode (om5),
`ifdef GRAY_CODEC_STATS_EN
    .enc_count(ec5),
    .dec_count(dc5),
`endif
    .out_data (od5)
  );

  // ---------------- parameter sweep ----------------
  localparam int NCFG = 11;

  function automatic int cfg_w(int g);
    case (g)
      0, 1:    return 2;
      2, 3, 4: return 5;
      5:       return 8;
      6, 7, 8: return 17;
      default: return 32;
    endcase
  endfunction

  function automatic int cfg_s(int g);
    case (g)
      0: return 1;  1: return 2;  2: return 1;  3: return 3;
      4: return 5;  5: return 3;  6: return 1;  7: return 3;
      8: return 17; 9: return 3;  default: return 32;
    endcase
  endfunction

  logic sw_rst_n = 1'b1;
  int   sw_done = 0;

  for (genvar g = 0; g < NCFG; g++) begin : g_sw
    localparam int W = cfg_w(g);
    localparam int S = cfg_s(g);

    logic         iv = 1'b0;
    logic         ir;
    logic         im = 1'b0;
    logic [W-1:0] id = '0;
    logic         ov;
    logic         orr = 1'b1;
    logic         om;
    logic [W-1:0] od;
`ifdef GRAY_CODEC_STATS_EN
    logic [15:0]  ec;
    logic [15:0]  dc;
`endif
    item_t        q[$];

    gray_codec_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk      (clk),
      .rst_n    (sw_rst_n),
      .in_valid (iv),
      .in_ready (ir),
      .in_mode  (im),
      .in_data  (id),
      .out_valid(ov),
      .out_ready(orr),
      .out_mode (om),
`ifdef GRAY_CODEC_STATS_EN
      .enc_count(ec),
      .dec_count(dc),
`endif
      .out_data (od)
    );

    always @(negedge clk) begin
      if (sw_rst_n) begin
        if (ov) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sweep_spurious w=%0d s=%0d", W, S);
          end else begin
            chk("sweep_out", q[0].mode, q[0].din, om, 64'(od), W);
            if (orr) void'(q.pop_front());
          end
        end
        if (iv && ir) q.push_back('{im, 64'(id)});
      end
    end

    initial begin
      @(posedge sw_rst_n);
      for (int n = 0; n < 400; n++) begin
        @(posedge clk);
        #1;
        iv  = ($urandom_range(0, 3) != 0);
        im  = 1'($urandom_range(0, 1));
        id  = W'({$urandom, $urandom});
        orr = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
      iv  = 1'b0;
      orr = 1'b1;
      repeat (S + 3) @(posedge clk);
      #1;
      expect1("sweep_drain", 64'(q.size()), 64'd0);
      sw_done++;
    end
  end

  // ---------------- main sequence ----------------
  task automatic lat_check(string nm, logic m, logic [7:0] d, logic [7:0] exp);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_mode   = m;
    in_data   = d;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expect1({nm, "_early"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    expect1({nm, "_valid"}, 64'(out_valid), 64'd1);
    expect1({nm, "_data"}, 64'(out_data), 64'(exp));
    expect1({nm, "_mode"}, 64'(out_mode), 64'(m));
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   f0;
    logic [7:0] snap;

    #2;
    rst_n    = 1'b0;
    sw_rst_n = 1'b0;
    #1;
    expect1("rst_out_valid", 64'(out_valid), 64'd0);
    expect1("rst_out_data", 64'(out_data), 64'd0);
    expect1("rst_out_mode", 64'(out_mode), 64'd0);
    expect1("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #2;
    rst_n    = 1'b1;
    sw_rst_n = 1'b1;

    lat_check("enc_b4", 1'b0, 8'hB4, 8'hEE);
    lat_check("enc_ff", 1'b0, 8'hFF, 8'h80);
    lat_check("dec_ee", 1'b1, 8'hEE, 8'hB4);
    lat_check("dec_80", 1'b1, 8'h80, 8'hFF);

    @(posedge clk);
    #1;
    iv5 = 1'b1;
    im5 = 1'b0;
    id5 = 5'b10110;
    @(posedge clk);
    #1;
    im5 = 1'b1;
    id5 = 5'b11101;
    expect1("w5_enc_valid", 64'(ov5), 64'd1);
    expect1("w5_enc_data", 64'(od5), 64'(5'b11101));
    expect1("w5_enc_mode", 64'(om5), 64'd0);
    @(posedge clk);
    #1;
    iv5 = 1'b0;
    expect1("w5_dec_data", 64'(od5), 64'(5'b10110));
    expect1("w5_dec_mode", 64'(om5), 64'd1);

    // Full-rate stream of all 256 values, alternating mode.
    f0 = out_fires;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_mode  = 1'(i % 2);
      in_data  = 8'(i);
      @(negedge clk);
      expect1("stream_in_ready", 64'(in_ready), 64'd1);
      if (i >= 2) expect1("stream_no_gap", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect1("stream_count", 64'(out_fires - f0), 64'd256);

    // Backpressure: fill, stall three cycles, release.
    f0 = out_fires;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_data   = 8'h3C;
    @(posedge clk);
    #1;
    in_mode = 1'b1;
    in_data = 8'h5A;
    @(posedge clk);
    #1;
    in_mode = 1'b0;
    in_data = 8'hC3;
    snap    = out_data;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      expect1("stall_in_ready", 64'(in_ready), 64'd0);
      expect1("stall_out_valid", 64'(out_valid), 64'd1);
      expect1("stall_out_data", 64'(out_data), 64'(snap));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    expect1("stall_count", 64'(out_fires - f0), 64'd3);
    expect1("stall_drain", 64'(mq.size()), 64'd0);

    // Asynchronous reset with two words in flight.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 8'h11;
    @(posedge clk);
    #1;
    in_data = 8'h22;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    f0 = out_fires;
    #1;
    rst_n = 1'b0;
    #1;
    expect1("arst_out_valid", 64'(out_valid), 64'd0);
    expect1("arst_in_ready", 64'(in_ready), 64'd1);
    expect1("arst_out_data", 64'(out_data), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    lat_check("post_rst", 1'b1, 8'h6B, 8'(g2b(64'h6B, 8)));
    @(posedge clk);
    #1;
    expect1("post_rst_count", 64'(out_fires - f0), 64'd1);

    // Random traffic with random backpressure.
    for (int n = 0; n < 500; n++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_mode   = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    expect1("rand_drain", 64'(mq.size()), 64'd0);
    expect1("rand_idle", 64'(out_valid), 64'd0);

`ifdef GRAY_CODEC_STATS_EN
    expect1("stats_enc_model", 64'(enc_count), 64'(enc_m));
    expect1("stats_dec_model", 64'(dec_count), 64'(dec_m));
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_mode  = (i >= 3);
      in_data  = 8'(i * 37);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    expect1("stats_enc3", 64'(enc_count), 64'd3);
    expect1("stats_dec2", 64'(dec_count), 64'd2);
    in_valid = 1'b1;
    in_mode  = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      #1;
      in_data = 8'(i);
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    expect1("stats_dec_sat", 64'(dec_count), 64'hFFFF);
    expect1("stats_enc_hold", 64'(enc_count), 64'd3);
`endif

    for (int t = 0; t < 3000 && sw_done < NCFG; t++) @(posedge clk);
    expect1("sweep_done", 64'(sw_done), 64'(NCFG));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
